dac_gain_ramp: RTL and testbench



---
 rtl/dac_gain_ramp.sv | 184 ++++++++++++++++++
 tb/tb_dac_gain_ramp.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dac_gain_ramp.sv
// Scales NUMBER_OF_LINE parallel signed samples by a click-free ramped Q2.14 gain and saturates them.
// Latency: 3 clocks from the capture edge to data_out; control changes reach data_out 4 clocks after the edge that updates the gain.
// Backpressure: none, one sample vector is accepted and one produced every clock.
// Optional feature macro: DAC_GAIN_SAT_FLAG_EN builds the sticky sat_flag (otherwise tied low, sat_clear ignored).
module dac_gain_ramp #(
  parameter int NUMBER_OF_LINE = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [15:0]                  gain_target,
  input  logic [15:0]                  ramp_step,
  input  logic                         sat_clear,
  input  logic [16*NUMBER_OF_LINE-1:0] data_in,
  output logic [16*NUMBER_OF_LINE-1:0] data_out,
  output logic [15:0]                  gain_current,
  output logic                         muted,
  output logic                         ramp_busy,
  output logic                         sat_flag
);

  localparam int N = NUMBER_OF_LINE;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [15:0]        gain_q;
  logic [15:0]        gain_d;
  logic [15:0]        target;
  logic [16:0]        up_sum;
  logic signed [16:0] down_diff;

  // Muting is just ramping toward a zero target.
  assign target    = enable ? gain_target : 16'h0000;
  // 17-bit arithmetic so neither direction can wrap before clamping to the target.
  assign up_sum    = {1'b0, gain_q} + {1'b0, ramp_step};
  assign down_diff = $signed({1'b0, gain_q}) - $signed({1'b0, ramp_step});

  // State and gain register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MUTED;
      gain_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  // Next gain steps toward the effective target; next state is derived from where the new gain lands.
  always_comb begin
    gain_d  = gain_q;
    state_d = state_q;
    if (ramp_step == 16'h0000) begin
      gain_d = target;
    end else if (gain_q < target) begin
      gain_d = (up_sum > {1'b0, target}) ? target : up_sum[15:0];
    end else if (gain_q > target) begin
      gain_d = (down_diff < $signed({1'b0, target})) ? target : down_diff[15:0];
    end
    if (gain_d < target) begin
      state_d = RAMP_UP;
    end else if (gain_d > target) begin
      state_d = RAMP_DOWN;
    end else if (target != 16'h0000) begin
      state_d = ACTIVE;
    end else begin
      state_d = MUTED;
    end
  end

  // Status outputs decode the registered state only.
  always_comb begin
    muted     = 1'b0;
    ramp_busy = 1'b0;
    case (state_q)
      MUTED:     muted     = 1'b1;
      RAMP_UP:   ramp_busy = 1'b1;
      RAMP_DOWN: ramp_busy = 1'b1;
      default:   ;
    endcase
  end

  assign gain_current = gain_q;

  // ------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------
  logic signed [15:0] s1_lane   [N];
  logic        [15:0] s1_gain;
  logic signed [32:0] s2_prod   [N];
  logic signed [32:0] rounded   [N];
  logic signed [18:0] s3_scaled [N];
  logic        [15:0] sat_lane  [N];
  logic [N-1:0]       lane_sat;

  // Stage 1: capture the samples together with the gain that was in force before this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_gain <= 16'h0000;
      for (int k = 0; k < N; k++) s1_lane[k] <= '0;
    end else begin
      s1_gain <= gain_q;
      for (int k = 0; k < N; k++) s1_lane[k] <= $signed(data_in[16*k +: 16]);
    end
  end

  // Stage 2: signed sample times zero-extended gain, full 33-bit product.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N; k++) s2_prod[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++)
        s2_prod[k] <= 33'(s1_lane[k]) * 33'($signed({1'b0, s1_gain}));
    end
  end

  // Round half up before dropping the 14 fraction bits.
  always_comb begin
    for (int k = 0; k < N; k++) rounded[k] = s2_prod[k] + 33'sd8192;
  end

  // Stage 3: keep the rounded, arithmetically shifted value (19 bits covers the full range).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N; k++) s3_scaled[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) s3_scaled[k] <= rounded[k][32:14];
    end
  end

  // Clamp each lane to the 16-bit signed range and flag lanes that needed it.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      sat_lane[k] = s3_scaled[k][15:0];
      lane_sat[k] = 1'b0;
      if (s3_scaled[k] > 19'sd32767) begin
        sat_lane[k] = 16'h7FFF;
        lane_sat[k] = 1'b1;
      end else if (s3_scaled[k] < -19'sd32768) begin
        sat_lane[k] = 16'h8000;
        lane_sat[k] = 1'b1;
      end
    end
  end

  // Output register toward the DAC tile.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= '0;
    end else begin
      for (int k = 0; k < N; k++) data_out[16*k +: 16] <= sat_lane[k];
    end
  end

`ifdef DAC_GAIN_SAT_FLAG_EN
  logic sat_q;

  // Sticky saturation flag; a new saturation event beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else if (|lane_sat) begin
      sat_q <= 1'b1;
    end else if (sat_clear) begin
      sat_q <= 1'b0;
    end
  end

  assign sat_flag = sat_q;
`else
  logic unused_sat_sig;

  assign unused_sat_sig = sat_clear ^ (|lane_sat);
  assign sat_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_dac_gain_ramp.sv
// Directed bench for dac_gain_ramp: ramps, mute reversal, table of gain/sample vectors, reset mid-ramp.
// Latency under test: 3 clocks capture-to-output.
// Backpressure: none in the DUT; the bench drives one vector per clock.
module tb_dac_gain_ramp;

  localparam int N = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [15:0]    gain_target = 16'h0000;
  logic [15:0]    ramp_step = 16'h0000;
  logic           sat_clear = 1'b0;
  logic [16*N-1:0] data_in = '0;
  logic [16*N-1:0] data_out;
  logic [15:0]    gain_current;
  logic           muted;
  logic           ramp_busy;
  logic           sat_flag;

  int errors = 0;
  int checks = 0;

  dac_gain_ramp #(.NUMBER_OF_LINE(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .gain_target  (gain_target),
    .ramp_step    (ramp_step),
    .sat_clear    (sat_clear),
    .data_in      (data_in),
    .data_out     (data_out),
    .gain_current (gain_current),
    .muted        (muted),
    .ramp_busy    (ramp_busy),
    .sat_flag     (sat_flag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] gain;
    logic [15:0] in0, in1, in2, in3;
    logic [15:0] ex0, ex1, ex2, ex3;
    bit          sat;
  } vec_t;

  vec_t vt [7];

  function automatic logic [127:0] rep4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a, d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [15:0] exp_gain [6];
  logic        exp_busy [6];
  logic [15:0] exp_out  [5];
  logic        exp_sat;

  initial begin
    vt[0] = '{16'h4000, 16'd1000, -16'sd1000, 16'd0, 16'h7FFF,
              16'd1000, -16'sd1000, 16'd0, 16'h7FFF, 1'b0};
    vt[1] = '{16'h2000, 16'd3, -16'sd3, 16'd1, -16'sd1,
              16'd2, -16'sd1, 16'd1, 16'd0, 1'b0};
    vt[2] = '{16'h8000, 16'h7FFF, 16'h8000, 16'd100, 16'd0,
              16'h7FFF, 16'h8000, 16'd200, 16'd0, 1'b1};
    vt[3] = '{16'h6000, 16'd1, -16'sd1, 16'd3, -16'sd3,
              16'd2, -16'sd1, 16'd5, -16'sd4, 1'b0};
    vt[4] = '{16'hFFFF, 16'd10000, -16'sd10000, 16'd1, 16'd0,
              16'h7FFF, 16'h8000, 16'd4, 16'd0, 1'b1};
    vt[5] = '{16'h0000, 16'd123, -16'sd456, 16'h7FFF, 16'h8000,
              16'd0, 16'd0, 16'd0, 16'd0, 1'b0};
    vt[6] = '{16'h4001, 16'd16384, -16'sd16384, 16'd2, -16'sd2,
              16'd16385, -16'sd16385, 16'd2, -16'sd2, 1'b0};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset data_out", 128'(data_out), '0);
    check("reset gain_current", 128'(gain_current), 128'h0);
    check("reset muted", 128'(muted), 128'h1);
    check("reset ramp_busy", 128'(ramp_busy), 128'h0);
    check("reset sat_flag", 128'(sat_flag), 128'h0);

    // Unmute ramp 0 -> 0x4000 in steps of 0x1000, lanes at 1000
    exp_gain = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h4000, 16'h4000};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_out  = '{16'd0, 16'd250, 16'd500, 16'd750, 16'd1000};
    enable = 1'b1;
    gain_target = 16'h4000;
    ramp_step = 16'h1000;
    data_in = rep4(16'd1000, 16'd1000, 16'd1000, 16'd1000);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e <= 4) begin
        check($sformatf("ramp gain e%0d", e), 128'(gain_current), 128'(exp_gain[e-1]));
        check($sformatf("ramp busy e%0d", e), 128'(ramp_busy), 128'(exp_busy[e-1]));
        check($sformatf("ramp muted e%0d", e), 128'(muted), 128'h0);
      end
      if (e >= 4)
        check($sformatf("ramp data_out e%0d", e), 128'(data_out),
              rep4(exp_out[e-4], exp_out[e-4], exp_out[e-4], exp_out[e-4]));
    end

    // Mute for 3 clocks mid-level, then unmute: direction reverses with no dead cycle
    exp_gain = '{16'h3800, 16'h3000, 16'h2800, 16'h3000, 16'h3800, 16'h4000};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ramp_step = 16'h0800;
    enable = 1'b0;
    for (int e = 0; e < 6; e++) begin
      if (e == 3) enable = 1'b1;
      tick();
      check($sformatf("reverse gain e%0d", e), 128'(gain_current), 128'(exp_gain[e]));
      check($sformatf("reverse busy e%0d", e), 128'(ramp_busy), 128'(exp_busy[e]));
      check($sformatf("reverse muted e%0d", e), 128'(muted), 128'h0);
    end

    // Table of gain / sample vectors, each gain applied by an immediate step
    for (int i = 0; i < 7; i++) begin
      gain_target = vt[i].gain;
      ramp_step = 16'h0000;
      enable = 1'b1;
      sat_clear = 1'b1;
      data_in = '0;
      tick();
      sat_clear = 1'b0;
      check($sformatf("vec%0d gain", i), 128'(gain_current), 128'(vt[i].gain));
      data_in = rep4(vt[i].in0, vt[i].in1, vt[i].in2, vt[i].in3);
      tick();
      data_in = '0;
      repeat (3) tick();
      check($sformatf("vec%0d data_out", i), 128'(data_out),
            rep4(vt[i].ex0, vt[i].ex1, vt[i].ex2, vt[i].ex3));
`ifdef DAC_GAIN_SAT_FLAG_EN
      exp_sat = vt[i].sat;
`else
      exp_sat = 1'b0;
`endif
      check($sformatf("vec%0d sat_flag", i), 128'(sat_flag), 128'(exp_sat));
    end

    // Immediate jump with zero step
    ramp_step = 16'h0000;
    gain_target = 16'h1234;
    enable = 1'b1;
    tick();
    check("jump gain", 128'(gain_current), 128'h1234);
    check("jump busy", 128'(ramp_busy), 128'h0);
    check("jump muted", 128'(muted), 128'h0);

    // Slow ramp toward 0xFFFF, then reset mid-ramp
    ramp_step = 16'h0010;
    gain_target = 16'hFFFF;
    data_in = rep4(16'd5000, -16'sd5000, 16'd5000, -16'sd5000);
    repeat (5) tick();
    check("slow ramp gain", 128'(gain_current), 128'h1284);
    check("slow ramp busy", 128'(ramp_busy), 128'h1);
    reset = 1'b1;
    tick();
    check("midramp reset gain", 128'(gain_current), 128'h0);
    check("midramp reset muted", 128'(muted), 128'h1);
    check("midramp reset busy", 128'(ramp_busy), 128'h0);
    check("midramp reset data_out", 128'(data_out), '0);
    check("midramp reset sat_flag", 128'(sat_flag), 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
